// File: rtl/sinegen_pkg.sv
// Shared definitions for the two-channel sine generator controller:
// default widths and the sequencing FSM state encoding.
package sinegen_pkg;

  localparam int ADDRESS_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    CAP1 = 2'd3
  } state_e;

endpackage

// File: rtl/sinegen_phase_acc.sv
// Phase accumulator for one channel: synchronous reload or advance by a
// per-sample increment, wrapping modulo 2**W.
module phase_acc #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         adv_i,
  input  logic [W-1:0] incr_i,
  output logic [W-1:0] phase_o
);

  logic [W-1:0] phase_q;
  logic [W-1:0] phase_d;

  always_comb begin
    phase_d = phase_q;
    if (load_i) begin
      phase_d = load_val_i;
    end else if (adv_i) begin
      phase_d = phase_q + incr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/sinegen_ctrl.sv
// Two-channel sine sample sequencer sharing one synchronous ROM: each accepted
// tick reads channel 0 then channel 1 and emits a valid pulse per channel.
module sinegen_ctrl
  import sinegen_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     tick,
  input  logic                     load,
  input  logic [ADDRESS_WIDTH-1:0] offset1,
  input  logic [ADDRESS_WIDTH-1:0] incr0,
  input  logic [ADDRESS_WIDTH-1:0] incr1,
  input  logic                     clr_overrun,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_dout,
  output logic [DATA_WIDTH-1:0]    ch0_data,
  output logic [DATA_WIDTH-1:0]    ch1_data,
  output logic                     ch0_valid,
  output logic                     ch1_valid,
  output logic                     busy,
  output logic                     overrun
);

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   ch0_data_q;
  logic [DATA_WIDTH-1:0]   ch1_data_q;
  logic                    ch0_valid_q;
  logic                    ch1_valid_q;
  logic                    overrun_q;
  logic [ADDRESS_WIDTH-1:0] phase0;
  logic [ADDRESS_WIDTH-1:0] phase1;

  logic idle;
  logic accept;
  logic do_load;
  logic drop;

  assign idle    = (state_q == IDLE);
  // load wins over a same-cycle tick; that tick is silently discarded
  assign do_load = idle && load;
  assign accept  = idle && tick && en && !load;
  assign drop    = tick && !idle;

  phase_acc #(.W(ADDRESS_WIDTH)) u_acc0 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (do_load),
    .load_val_i ('0),
    .adv_i      (state_q == RD1),
    .incr_i     (incr0),
    .phase_o    (phase0)
  );

  phase_acc #(.W(ADDRESS_WIDTH)) u_acc1 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (do_load),
    .load_val_i (offset1),
    .adv_i      (state_q == CAP1),
    .incr_i     (incr1),
    .phase_o    (phase1)
  );

  // ROM data lags the address by one cycle, so RD1 sees rom[phase0] and CAP1 sees rom[phase1]
  assign rom_addr = (state_q == RD1) ? phase1 : phase0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch0_data_q  <= '0;
      ch1_data_q  <= '0;
      ch0_valid_q <= 1'b0;
      ch1_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      ch0_valid_q <= 1'b0;
      ch1_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) state_q <= RD0;
        RD0:  state_q <= RD1;
        RD1: begin
          state_q     <= CAP1;
          ch0_data_q  <= rom_dout;
          ch0_valid_q <= 1'b1;
        end
        CAP1: begin
          state_q     <= IDLE;
          ch1_data_q  <= rom_dout;
          ch1_valid_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign ch0_data  = ch0_data_q;
  assign ch1_data  = ch1_data_q;
  assign ch0_valid = ch0_valid_q;
  assign ch1_valid = ch1_valid_q;
  assign overrun   = overrun_q;
  assign busy      = !idle;

endmodule

// File: tb/tb_sinegen_ctrl.sv
// Directed bench for sinegen_ctrl; the ROM model returns addr ^ 0x3C so each
// captured sample identifies the address that was read.
module tb_sinegen_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       tick = 1'b0;
  logic       load = 1'b0;
  logic       clr_overrun = 1'b0;
  logic [7:0] offset1 = 8'h00;
  logic [7:0] incr0 = 8'h00;
  logic [7:0] incr1 = 8'h00;
  logic [7:0] rom_addr;
  logic [7:0] rom_dout;
  logic [7:0] ch0_data;
  logic [7:0] ch1_data;
  logic       ch0_valid;
  logic       ch1_valid;
  logic       busy;
  logic       overrun;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [7:0] i0;
    logic [7:0] i1;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  vec_t tbl[6];

  sinegen_ctrl #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .tick        (tick),
    .load        (load),
    .offset1     (offset1),
    .incr0       (incr0),
    .incr1       (incr1),
    .clr_overrun (clr_overrun),
    .rom_addr    (rom_addr),
    .rom_dout    (rom_dout),
    .ch0_data    (ch0_data),
    .ch1_data    (ch1_data),
    .ch0_valid   (ch0_valid),
    .ch1_valid   (ch1_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_dout <= rom_addr ^ 8'h3C;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Tick issued in the current cycle n; returns in cycle n+4 so back-to-back calls give period 4.
  task automatic run_seq(input logic [7:0] i0, input logic [7:0] i1,
                         input logic [7:0] e0, input logic [7:0] e1,
                         input bit drop_en, input string nm);
    incr0 = i0;
    incr1 = i1;
    en    = 1'b1;
    tick  = 1'b1;
    chk({nm, ".idle_n"}, busy, 1'b0);
    step();
    tick = 1'b0;
    chk({nm, ".busy_n1"}, busy, 1'b1);
    chk({nm, ".v0_n1"}, ch0_valid, 1'b0);
    if (drop_en) begin
      en      = 1'b0;
      load    = 1'b1;
      offset1 = 8'h99;
    end
    step();
    load = 1'b0;
    chk({nm, ".vld_n2"}, {ch0_valid, ch1_valid}, 2'b00);
    step();
    chk({nm, ".v0_n3"}, ch0_valid, 1'b1);
    chk({nm, ".v1_n3"}, ch1_valid, 1'b0);
    chk({nm, ".d0"}, ch0_data, e0);
    step();
    chk({nm, ".v1_n4"}, ch1_valid, 1'b1);
    chk({nm, ".v0_n4"}, ch0_valid, 1'b0);
    chk({nm, ".d1"}, ch1_data, e1);
    chk({nm, ".d0_hold"}, ch0_data, e0);
    chk({nm, ".busy_n4"}, busy, 1'b0);
  endtask

  initial begin
    tbl[0] = '{8'h01, 8'h04, 8'h3C, 8'h3C};
    tbl[1] = '{8'h01, 8'h04, 8'h3D, 8'h38};
    tbl[2] = '{8'h01, 8'h04, 8'h3E, 8'h34};
    tbl[3] = '{8'hFB, 8'h04, 8'h3F, 8'h30};
    tbl[4] = '{8'h03, 8'h04, 8'hC2, 8'h2C};
    tbl[5] = '{8'h03, 8'h04, 8'h3D, 8'h28};

    #1;
    chk("rst.busy", busy, 1'b0);
    chk("rst.ovr", overrun, 1'b0);
    chk("rst.vld", {ch0_valid, ch1_valid}, 2'b00);
    chk("rst.data", {ch0_data, ch1_data}, 16'h0000);
    chk("rst.addr", rom_addr, 8'h00);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Periodic ticks, then phase0 steered to 0xFE and wrapped with incr0=3.
    for (int k = 0; k < 6; k++) begin
      run_seq(tbl[k].i0, tbl[k].i1, tbl[k].e0, tbl[k].e1, 1'b0, $sformatf("vec%0d", k));
    end

    // Overrun: ticks at cycles 0 and 2, clear collides with a dropped tick in cycle 3.
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    tick = 1'b1;
    chk("ovr.c2", overrun, 1'b0);
    step();
    clr_overrun = 1'b1;
    chk("ovr.c3", overrun, 1'b1);
    chk("ovr.v0", ch0_valid, 1'b1);
    chk("ovr.d0", ch0_data, 8'h38);
    step();
    tick = 1'b0;
    chk("ovr.set_wins", overrun, 1'b1);
    chk("ovr.v1", ch1_valid, 1'b1);
    chk("ovr.d1", ch1_data, 8'h24);
    step();
    clr_overrun = 1'b0;
    chk("ovr.cleared", overrun, 1'b0);
    chk("ovr.one_seq", busy, 1'b0);
    step();
    chk("ovr.no_restart", busy, 1'b0);

    // load with a same-cycle tick: reload only, no sequence and no overrun.
    load    = 1'b1;
    offset1 = 8'h40;
    tick    = 1'b1;
    step();
    load = 1'b0;
    tick = 1'b0;
    chk("load.busy", busy, 1'b0);
    chk("load.ovr", overrun, 1'b0);
    step();
    run_seq(8'h01, 8'h04, 8'h3C, 8'h7C, 1'b0, "load");

    // en low in IDLE ignores the tick; en low (and a stray load) in RD0 do not disturb.
    en   = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("en.busy", busy, 1'b0);
    chk("en.ovr", overrun, 1'b0);
    run_seq(8'h01, 8'h04, 8'h3D, 8'h78, 1'b1, "endrop");

    // Asynchronous reset in RD1 with overrun and data registers non-zero.
    en   = 1'b1;
    tick = 1'b1;
    step();
    step();
    tick = 1'b0;
    chk("arst.pre_ovr", overrun, 1'b1);
    chk("arst.pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst.busy", busy, 1'b0);
    chk("arst.ovr", overrun, 1'b0);
    chk("arst.data", {ch0_data, ch1_data}, 16'h0000);
    chk("arst.addr", rom_addr, 8'h00);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("arst.vld%0d", k), {ch0_valid, ch1_valid}, 2'b00);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("arst.quiet%0d", k), {busy, ch0_valid, ch1_valid}, 3'b000);
    end
    run_seq(8'h01, 8'h04, 8'h3C, 8'h3C, 1'b0, "restart");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
